// File: rtl/rv_sram_bist.sv
// rv_sram_bist: self-checking SRAM tester. Writes a selectable pattern over a
// word range through the SRAM driver request port, reads it back and compares.
// It counts mismatches and captures the first failing address and data. An
// optional byte-lane pass checks partial byte-enable writes.
module rv_sram_bist #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned NUM_WORDS = 16,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned ERR_W     = 16
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic              bytelane_en_i,
  input  logic [31:0]       seed_i,
  output logic              data_req_o,
  output logic              data_we_o,
  output logic [XLEN/8-1:0] data_be_o,
  output logic [XLEN-1:0]   data_addr_o,
  output logic [XLEN-1:0]   data_wdata_o,
  input  logic              data_rvalid_i,
  input  logic [XLEN-1:0]   data_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic [XLEN-1:0]   first_err_addr_o,
  output logic [XLEN-1:0]   first_err_data_o
);
  localparam int unsigned BW = XLEN / 8;
  localparam int unsigned LW = (BW > 1) ? $clog2(BW) : 1;
  localparam int unsigned IW = $clog2(NUM_WORDS);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_BWR, S_BRD, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [31:0]       lfsr_q, lfsr_d, seed_q, seed_d, seed_eff, lfsr_nx;
  logic [1:0]        mode_q, mode_d;
  logic              ble_q, ble_d, to_q, to_d, done_q, done_d;
  logic [WW-1:0]     wdog_q, wdog_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [XLEN-1:0]   fea_q, fea_d, fed_q, fed_d;

  logic              busy, accept, last;
  logic [XLEN-1:0]   addr, pat, exp_lane, expected;
  logic [LW-1:0]     lane;
  logic [BW-1:0]     be_lane;

  assign busy     = (state_q == S_WR) || (state_q == S_RD) ||
                    (state_q == S_BWR) || (state_q == S_BRD);
  assign accept   = busy && data_rvalid_i;
  assign last     = (idx_q == IW'(NUM_WORDS - 1));
  assign addr     = XLEN'(BASE_ADDR) + (XLEN'(idx_q) << $clog2(BW));
  assign lane     = LW'(32'(idx_q) % BW);
  assign be_lane  = BW'(1) << lane;
  assign lfsr_nx  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
  assign seed_eff = (seed_i == 32'h0) ? 32'h1 : seed_i;

  // Pattern generator, plus the byte-lane-merged expectation for BRD
  always_comb begin
    pat = '0;
    case (mode_q)
      2'd0:    pat = addr;
      2'd1:    pat = XLEN'(1) << (32'(idx_q) % XLEN);
      2'd2:    pat = idx_q[0] ? {(XLEN/2){2'b10}} : {(XLEN/2){2'b01}};
      default: pat = lfsr_q[XLEN-1:0];
    endcase
    exp_lane = pat;
    for (int b = 0; b < int'(BW); b++)
      if (LW'(b) == lane) exp_lane[b*8 +: 8] = ~pat[b*8 +: 8];
    expected = (state_q == S_BRD) ? exp_lane : pat;
  end

  // Request-side outputs: all zero outside the active phases; req drops in the rvalid cycle
  assign data_req_o   = busy && !data_rvalid_i;
  assign data_we_o    = (state_q == S_WR) || (state_q == S_BWR);
  assign data_be_o    = !busy ? '0 : (state_q == S_BWR) ? be_lane : '1;
  assign data_addr_o  = busy ? addr : '0;
  assign data_wdata_o = (state_q == S_WR) ? pat : (state_q == S_BWR) ? ~pat : '0;

  assign busy_o           = busy;
  assign done_o           = done_q;
  assign pass_o           = done_q && (err_q == '0) && !to_q;
  assign timeout_o        = to_q;
  assign err_cnt_o        = err_q;
  assign first_err_addr_o = fea_q;
  assign first_err_data_o = fed_q;

  // Sequencer next state: start, per-transaction advance, compare and watchdog
  always_comb begin
    state_d = state_q; idx_d = idx_q; lfsr_d = lfsr_q; seed_d = seed_q;
    mode_d = mode_q; ble_d = ble_q; to_d = to_q; done_d = done_q;
    wdog_d = wdog_q; err_d = err_q; fea_d = fea_q; fed_d = fed_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          mode_d  = mode_i;
          ble_d   = bytelane_en_i;
          seed_d  = seed_eff;
          lfsr_d  = seed_eff;
          idx_d   = '0;
          wdog_d  = '0;
          err_d   = '0;
          fea_d   = '0;
          fed_d   = '0;
          to_d    = 1'b0;
          done_d  = 1'b0;
          state_d = S_WR;
        end
      end
      default: begin
        if (accept) begin
          wdog_d = '0;
          if (((state_q == S_RD) || (state_q == S_BRD)) && (data_rdata_i != expected)) begin
            if (err_q != '1) err_d = err_q + ERR_W'(1);
            if (err_q == '0) begin
              fea_d = addr;
              fed_d = data_rdata_i;
            end
          end
          if (last) begin
            // Phase change: restart the index and the pattern sequence
            idx_d  = '0;
            lfsr_d = seed_q;
            case (state_q)
              S_WR:    state_d = S_RD;
              S_RD:    state_d = ble_q ? S_BWR : S_DONE;
              S_BWR:   state_d = S_BRD;
              default: state_d = S_DONE;
            endcase
            if (state_d == S_DONE) done_d = 1'b1;
          end else begin
            idx_d  = idx_q + IW'(1);
            lfsr_d = lfsr_nx;
          end
        end else if (wdog_q == WW'(TIMEOUT)) begin
          to_d    = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      lfsr_q  <= 32'h1;
      seed_q  <= 32'h1;
      mode_q  <= '0;
      ble_q   <= 1'b0;
      to_q    <= 1'b0;
      done_q  <= 1'b0;
      wdog_q  <= '0;
      err_q   <= '0;
      fea_q   <= '0;
      fed_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
      seed_q  <= seed_d;
      mode_q  <= mode_d;
      ble_q   <= ble_d;
      to_q    <= to_d;
      done_q  <= done_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      fea_q   <= fea_d;
      fed_q   <= fed_d;
    end
  end
endmodule

// File: tb/tb_rv_sram_bist.sv
// tb_rv_sram_bist: directed bench with a 2-cycle-latency memory model and
// fault knobs (stuck bit, ignored byte enables, missing rvalid).
module tb_rv_sram_bist;
  logic        clk_i = 1'b0, arst_i = 1'b1, start_i = 1'b0, bytelane_en_i = 1'b0;
  logic [1:0]  mode_i = '0;
  logic [31:0] seed_i = '0;
  logic        data_req_o, data_we_o, data_rvalid_i;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic        busy_o, done_o, pass_o, timeout_o;
  logic [15:0] err_cnt_o;
  logic [31:0] first_err_addr_o, first_err_data_o;

  int n_chk = 0, n_err = 0;

  // model state and knobs
  logic [31:0] mem [16];
  logic [31:0] wlog [$];
  logic [3:0]  blog [$];
  int          wcnt, hcnt = 0;
  logic        stuck_en = 0, ignore_be = 0, hang_en = 0;
  logic        rv_q;
  logic [31:0] rd_q;

  assign data_rvalid_i = rv_q;
  assign data_rdata_i  = rd_q;

  rv_sram_bist #(.XLEN(32), .BASE_ADDR(0), .NUM_WORDS(16), .TIMEOUT(64), .ERR_W(16)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .start_i(start_i), .mode_i(mode_i),
    .bytelane_en_i(bytelane_en_i), .seed_i(seed_i),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
    .err_cnt_o(err_cnt_o), .first_err_addr_o(first_err_addr_o),
    .first_err_data_o(first_err_data_o));

  always #5 clk_i = ~clk_i;

  // memory model: rvalid after the request has been high for two cycles
  always @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rv_q <= 1'b0; rd_q <= '0; wcnt <= 0;
    end else begin
      rv_q <= 1'b0;
      if (data_req_o) begin
        if (hang_en && data_we_o && data_addr_o == 32'h8) hcnt <= hcnt + 1;
        else if (wcnt == 1) begin
          rv_q <= 1'b1; wcnt <= 0;
          if (data_we_o) begin
            wlog.push_back(data_wdata_o);
            blog.push_back(data_be_o);
            for (int b = 0; b < 4; b++)
              if (ignore_be || data_be_o[b]) mem[data_addr_o[5:2]][b*8 +: 8] <= data_wdata_o[b*8 +: 8];
          end else begin
            rd_q <= mem[data_addr_o[5:2]] |
                    ((stuck_en && data_addr_o[5:2] == 4'd5) ? 32'h8 : 32'h0);
          end
        end else wcnt <= wcnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [1:0] m, input logic ble, input logic [31:0] seed);
    int c;
    @(negedge clk_i);
    mode_i = m; bytelane_en_i = ble; seed_i = seed; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("req_latency", 32'(data_req_o), 32'd1);
    c = 0;
    while (!done_o && c < 3000) begin @(negedge clk_i); c++; end
    chk("done", 32'(done_o), 32'd1);
  endtask

  int base;
  logic [31:0] w15_seed0;

  initial begin
    // reset state
    #12;
    chk("rst_req", 32'(data_req_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_pass", 32'(pass_o), 0);
    chk("rst_addr", data_addr_o, 0);
    @(negedge clk_i); arst_i = 1'b0;

    // mode 0 clean
    base = wlog.size();
    run(2'd0, 1'b0, 0);
    chk("m0_pass", 32'(pass_o), 1);
    chk("m0_err", 32'(err_cnt_o), 0);
    chk("m0_busy", 32'(busy_o), 0);
    chk("m0_nwr", wlog.size() - base, 16);
    chk("m0_w5", wlog[base+5], 32'h14);
    chk("m0_w15", wlog[base+15], 32'h3C);

    // mode 1 with bit 3 stuck-at-1 on word 5
    stuck_en = 1;
    run(2'd1, 1'b0, 0);
    stuck_en = 0;
    chk("m1_err", 32'(err_cnt_o), 1);
    chk("m1_fea", first_err_addr_o, 32'h14);
    chk("m1_fed", first_err_data_o, 32'h28);
    chk("m1_pass", 32'(pass_o), 0);

    // mode 3 seed 0 then seed 1
    base = wlog.size();
    run(2'd3, 1'b0, 32'h0);
    chk("lfsr0_w0", wlog[base], 32'h1);
    chk("lfsr0_w1", wlog[base+1], 32'h80200003);
    chk("lfsr0_w2", wlog[base+2], 32'hC0300002);
    chk("lfsr0_pass", 32'(pass_o), 1);
    w15_seed0 = wlog[base+15];
    base = wlog.size();
    run(2'd3, 1'b0, 32'h1);
    chk("lfsr1_w0", wlog[base], 32'h1);
    chk("lfsr1_w1", wlog[base+1], 32'h80200003);
    chk("lfsr1_w15", wlog[base+15], w15_seed0);
    chk("lfsr1_pass", 32'(pass_o), 1);

    // byte-lane pass, mode 2
    base = wlog.size();
    run(2'd2, 1'b1, 0);
    chk("bl_nwr", wlog.size() - base, 32);
    chk("bl_be2", 32'(blog[base+18]), 32'h4);
    chk("bl_wd2", wlog[base+18], 32'hAAAAAAAA);
    chk("bl_mem2", mem[2], 32'h55AA5555);
    chk("bl_be5", 32'(blog[base+21]), 32'h2);
    chk("bl_pass", 32'(pass_o), 1);
    ignore_be = 1;
    run(2'd2, 1'b1, 0);
    ignore_be = 0;
    chk("nobe_err", 32'(err_cnt_o), 16);
    chk("nobe_pass", 32'(pass_o), 0);

    // missing rvalid on the 3rd write
    base = hcnt;
    hang_en = 1;
    run(2'd0, 1'b0, 0);
    hang_en = 0;
    chk("to_cycles", hcnt - base, 65);
    chk("to_flag", 32'(timeout_o), 1);
    chk("to_pass", 32'(pass_o), 0);
    chk("to_req", 32'(data_req_o), 0);

    // reset mid-RD
    @(negedge clk_i);
    mode_i = 2'd0; bytelane_en_i = 0; start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    for (int c = 0; c < 500 && !(busy_o && !data_we_o); c++) @(negedge clk_i);
    chk("in_rd", 32'(busy_o && !data_we_o), 1);
    repeat (4) @(negedge clk_i);
    #2 arst_i = 1'b1;
    #1;
    chk("ar_req", 32'(data_req_o), 0);
    chk("ar_busy", 32'(busy_o), 0);
    chk("ar_done", 32'(done_o), 0);
    chk("ar_to", 32'(timeout_o), 0);
    chk("ar_addr", data_addr_o, 0);
    @(negedge clk_i); arst_i = 1'b0;

    // clean run with a start pulse while busy that must be ignored
    base = wlog.size();
    @(negedge clk_i);
    mode_i = 2'd0; start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    mode_i = 2'd2; start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    for (int c = 0; c < 3000 && !done_o; c++) @(negedge clk_i);
    chk("cl_done", 32'(done_o), 1);
    chk("cl_pass", 32'(pass_o), 1);
    chk("cl_to", 32'(timeout_o), 0);
    chk("cl_nwr", wlog.size() - base, 16);
    chk("cl_w15", wlog[base+15], 32'h3C);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/rv_sram_bist.md
Name: rv_sram_bist

Overview:
- Self-checking memory tester: drives the core data-memory request interface of the SRAM driver, writing a selectable pattern over a word range and reading it back.
- Compares each returned word against the regenerated expected value, counts errors and captures the first failure.
- Optional byte-lane pass exercises partial byte-enable writes.
- Sits between board-level controls (keys/switches/hex display) and rv_sram_driver.
- Replaces the fixed-sequence manual write/read test.

Parameters:
- XLEN, 32, data width in bits; legal values 16 or 32.
- BASE_ADDR, 0, byte address of the first tested word; must be XLEN/8 aligned.
- NUM_WORDS, 16, number of words tested; must be ≥2.
- TIMEOUT, 1024, maximum cycles to wait for data_rvalid_i per transaction.
- ERR_W, 16, width of the error counter.

Ports:
- clk_i  in  1  clock
- arst_i  in  1  asynchronous active-high reset
- start_i  in  1  start pulse; sampled only when busy_o=0
- mode_i  in  2  pattern: 0 addr-as-data, 1 walking one, 2 checkerboard, 3 LFSR
- bytelane_en_i  in  1  run the byte-lane pass after the word pass
- seed_i  in  32  LFSR seed (mode 3)
- data_req_o  out  1  request to the SRAM driver
- data_we_o  out  1  write enable
- data_be_o  out  XLEN/8  byte enables
- data_addr_o  out  XLEN  byte address
- data_wdata_o  out  XLEN  write data
- data_rvalid_i  in  1  transaction complete (write acknowledge or read data valid)
- data_rdata_i  in  XLEN  read data
- busy_o  out  1  test in progress
- done_o  out  1  test finished; held until the next start or reset
- pass_o  out  1  valid when done_o=1: no errors and no timeout
- timeout_o  out  1  aborted on a missing rvalid
- err_cnt_o  out  ERR_W  mismatch count, saturating at all-ones
- first_err_addr_o  out  XLEN  address of the first mismatch
- first_err_data_o  out  XLEN  read data at the first mismatch

Behaviour:
- Reset: all outputs 0. State IDLE, idx=0, LFSR=1, watchdog=0. Reset mid-test drops data_req_o the same instant.
- States: IDLE, WR, RD, BWR, BRD, DONE.
  - IDLE/DONE -> WR on start_i (only when busy_o=0).
  - start_i latches mode_i, bytelane_en_i and seed_i. A zero seed is replaced by 1.
  - start_i clears err_cnt_o, first_err_*, timeout_o and done_o.
- Address: data_addr_o = BASE_ADDR + idx*(XLEN/8). idx counts 0..NUM_WORDS-1, then wraps to 0 at phase change.
- Patterns P(idx):
  - mode 0: data_addr_o.
  - mode 1: 1 << (idx mod XLEN).
  - mode 2: 0x5555… for even idx, 0xAAAA… for odd idx.
  - mode 3: 32-bit Galois LFSR, taps 0x80200003, lower XLEN bits. Advances once per completed transaction in a phase; reloaded from the seed at each phase start so read-back regenerates the write sequence.
- Handshake:
  - One transaction outstanding at a time.
  - data_req_o is high in WR/RD/BWR/BRD and is gated combinationally low in the cycle data_rvalid_i=1.
  - we/be/addr/wdata are stable from request assertion until rvalid.
  - Next request is asserted the cycle after rvalid (req low exactly one cycle between back-to-back transactions, matching the driver).
  - data_rvalid_i while not requesting is ignored.
- WR: we=1, be=all ones, wdata=P(idx). After the last word -> RD.
- RD: we=0, be=all ones.
  - On rvalid, compare data_rdata_i with P(idx).
  - Mismatch: err_cnt+1 (saturating). If err_cnt was 0, capture addr and rdata.
  - After the last word: go to BWR if bytelane enabled, else DONE.
- BWR: we=1, be = 1 << (idx mod XLEN/8), wdata = ~P(idx). After the last word -> BRD.
- BRD: full-word read. Expected value = P(idx) with lane (idx mod XLEN/8) replaced by the matching byte of ~P(idx). Error handling as in RD. After the last word -> DONE.
- Watchdog:
  - Counts cycles with data_req_o=1; cleared on rvalid.
  - Reaching TIMEOUT: timeout_o=1, data_req_o low next cycle, -> DONE with pass_o=0.
- DONE: busy_o=0, done_o=1, pass_o = (err_cnt==0 && !timeout_o). busy_o=1 in WR/RD/BWR/BRD.
- Latency: data_req_o rises the cycle after start_i is sampled.

Test Plan:
- Ideal memory model with 2-cycle rvalid, NUM_WORDS=16, mode 0: 16 writes to addr 0x0..0x3C with wdata=addr, then 16 reads. done_o=1, pass_o=1, err_cnt_o=0.
- Model forces bit 3 stuck-at-1 on word 5, mode 1: err_cnt_o=1, first_err_addr_o=0x14, first_err_data_o=0x28.
- Mode 3, seed 0 vs seed 1: identical write sequences; first wdata=0x00000001, second=0x80200003; pass_o=1.
- bytelane_en_i=1, mode 2: word 2 written be=0100, wdata=0xAAAAAAAA, read back 0x55AA5555. Model ignoring be -> err_cnt_o=16.
- Model never asserts rvalid on the 3rd write, TIMEOUT=64: data_req_o low 65 cycles after that request; timeout_o=1, pass_o=0, done_o=1.
- arst_i pulsed mid-RD: data_req_o low immediately, all outputs 0; start_i afterwards runs a clean full test. start_i while busy is ignored.
